// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates core (ex_*) and fetch (fe_*) requests onto a single
// shared memory bus with one transaction outstanding at a time.
//   clk, a_rst          : clock, synchronous active-low reset
//   ex_rq*/ex_rq_ack    : core request (read/write, 8/16-bit, tagged rsa/rsb)
//   fe_rq*/fe_rq_ack    : fetch request (16-bit read only)
//   bus_*               : shared bus request / handshake / read return
//   mem_data_*          : core read return, tagged with the captured ex_rq_t
//   fe_data*            : fetch read return
//   err_timeout         : pulse when a transaction is aborted on timeout
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        ex_rq,
    input  logic        ex_rq_cmd,
    input  logic        ex_rq_width,
    input  logic        ex_rq_t,
    input  logic [15:0] ex_rq_addr,
    input  logic [15:0] ex_rq_data,
    output logic        ex_rq_ack,
    input  logic        fe_rq,
    input  logic [15:0] fe_rq_addr,
    output logic        fe_rq_ack,
    output logic        bus_req,
    output logic        bus_cmd,
    output logic        bus_width,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_rvalid,
    input  logic [15:0] bus_rdata,
    output logic [15:0] mem_data_in,
    output logic        mem_data_wr,
    output logic        mem_data_t_wr,
    output logic [15:0] fe_data,
    output logic        fe_data_wr,
    output logic        err_timeout
);

    localparam int unsigned SW = 4;
    localparam int unsigned TW = 8;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);
    localparam logic          TMO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          owner_fe;
    logic          tag;

    logic          fe_forced;
    logic          core_win;
    logic [TW-1:0] tmo_next;
    logic          tmo_hit;

    // Grant decision and timeout detection for the current cycle
    always_comb begin
        fe_forced = fe_rq && (starve_cnt == STARVE_MAX);
        core_win  = ex_rq && !fe_forced;
        tmo_next  = tmo_cnt + TW'(1);
        tmo_hit   = TMO_EN && (tmo_next == TMO_MAX);
    end

    // Arbitration FSM with registered bus and return outputs
    always_ff @(posedge clk) begin
        if (!a_rst) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            tmo_cnt       <= '0;
            owner_fe      <= 1'b0;
            tag           <= 1'b0;
            ex_rq_ack     <= 1'b0;
            fe_rq_ack     <= 1'b0;
            bus_req       <= 1'b0;
            bus_cmd       <= 1'b0;
            bus_width     <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            mem_data_in   <= '0;
            mem_data_wr   <= 1'b0;
            mem_data_t_wr <= 1'b0;
            fe_data       <= '0;
            fe_data_wr    <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            ex_rq_ack     <= 1'b0;
            fe_rq_ack     <= 1'b0;
            mem_data_wr   <= 1'b0;
            mem_data_t_wr <= 1'b0;
            fe_data_wr    <= 1'b0;
            err_timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_rq || fe_rq) begin
                        state   <= ISSUE;
                        bus_req <= 1'b1;
                        tmo_cnt <= '0;
                        if (core_win) begin
                            owner_fe  <= 1'b0;
                            tag       <= ex_rq_t;
                            bus_cmd   <= ex_rq_cmd;
                            bus_width <= ex_rq_width;
                            bus_addr  <= ex_rq_addr;
                            bus_wdata <= ex_rq_data;
                            ex_rq_ack <= 1'b1;
                            // Only count wins that made a waiting fetch wait
                            if (fe_rq && (starve_cnt != STARVE_MAX)) begin
                                starve_cnt <= starve_cnt + SW'(1);
                            end
                        end else begin
                            owner_fe   <= 1'b1;
                            tag        <= 1'b0;
                            bus_cmd    <= 1'b0;
                            bus_width  <= 1'b1;
                            bus_addr   <= fe_rq_addr;
                            bus_wdata  <= '0;
                            fe_rq_ack  <= 1'b1;
                            starve_cnt <= '0;
                        end
                    end
                end
                ISSUE: begin
                    // A write completes on bus_ack and beats a same-edge timeout
                    if (bus_ack && bus_cmd) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        state       <= IDLE;
                        bus_req     <= 1'b0;
                        tmo_cnt     <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_next;
                        if (bus_ack) begin
                            state   <= WAIT;
                            bus_req <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        state   <= IDLE;
                        tmo_cnt <= '0;
                        if (owner_fe) begin
                            fe_data    <= bus_rdata;
                            fe_data_wr <= 1'b1;
                        end else begin
                            mem_data_in   <= bus_rdata;
                            mem_data_wr   <= 1'b1;
                            mem_data_t_wr <= tag;
                        end
                    end else if (tmo_hit) begin
                        state       <= IDLE;
                        tmo_cnt     <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, 4: consecutive core wins over a waiting fetch before fetch is forced to win (range 1-15).
REQ-002 Parameter TIMEOUT, 64: maximum cycles from grant to completion before abort (0 = disabled, max 255).
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port a_rst  in  1  reset; synchronous and active-low (0 = reset, sampled on clk rising edge).
REQ-005 Ports ex_rq, ex_rq_cmd (1 = write), ex_rq_width (1 = 16-bit), ex_rq_t (0 = rsa, 1 = rsb)  in  1 each  core request, level, held until ex_rq_ack.
REQ-006 Ports ex_rq_addr, ex_rq_data  in  16 each  core address and write data.
REQ-007 Port ex_rq_ack  out  1  one-cycle pulse, core request captured.
REQ-008 Ports fe_rq  in  1, fe_rq_addr  in  16  fetch read request, always 16-bit, held until fe_rq_ack.
REQ-009 Port fe_rq_ack  out  1  one-cycle pulse, fetch request captured.
REQ-010 Ports bus_req, bus_cmd, bus_width  out  1 each; bus_addr, bus_wdata  out  16 each  shared memory bus request.
REQ-011 Ports bus_ack  in  1 (bus accepted request), bus_rvalid  in  1 (read data valid), bus_rdata  in  16.
REQ-012 Ports mem_data_in  out  16, mem_data_wr  out  1, mem_data_t_wr  out  1  core read return, tagged with captured ex_rq_t.
REQ-013 Ports fe_data  out  16, fe_data_wr  out  1  fetch read return.
REQ-014 Port err_timeout  out  1  one-cycle pulse on abort.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT; exactly one transaction outstanding at any time.
REQ-016 IDLE: on an edge where ex_rq or fe_rq is 1, latch winner's cmd/width/addr/data/tag/owner, go to ISSUE; ack pulse to winner only, during first ISSUE cycle.
REQ-017 Arbitration: core wins over fetch unless starve counter == STARVE_LIMIT, then fetch wins.
REQ-018 Starve counter (4-bit): +1 when core wins while fe_rq = 1; cleared when fetch is granted; saturates at STARVE_LIMIT.
REQ-019 ISSUE: bus_req = 1, bus_* driven from latched fields (fetch: cmd 0, width 1, wdata 0); on bus_ack write -> IDLE, read -> WAIT.
REQ-020 WAIT: bus_req = 0; on bus_rvalid register bus_rdata, next cycle pulse mem_data_wr (tag on mem_data_t_wr) or fe_data_wr per owner, return to IDLE in that same cycle.
REQ-021 Grant-to-return minimum: request seen at edge N, ack and bus_req in cycle N+1; bus_ack in N+1 plus bus_rvalid in N+2 gives data pulse in cycle N+3.
REQ-022 bus_rvalid in IDLE or ISSUE, and bus_ack outside ISSUE, are ignored.
REQ-023 Timeout counter (8-bit) cleared on grant, +1 each cycle in ISSUE/WAIT; on reaching TIMEOUT (TIMEOUT != 0) -> IDLE, err_timeout pulse, bus_req low, no data pulse, counter cleared.
REQ-024 Completion (bus_ack write / bus_rvalid read) on the same edge the counter reaches TIMEOUT: completion wins, no err_timeout.
REQ-025 Requests asserted during ISSUE/WAIT are not acked and not counted; arbitrated on first IDLE edge.
REQ-026 mem_data_in/fe_data hold last returned value between pulses.

Reset
REQ-027 a_rst = 0 at an edge: state IDLE, both counters 0, latched fields 0, all outputs 0 next cycle, including mid-transaction (transaction dropped, no pulse).
REQ-028 First arbitration possible at the first edge with a_rst = 1.

Verification
REQ-029 ex_rq=1 and fe_rq=1 in IDLE, ex read addr 0x1234, t=1 -> ex_rq_ack, bus_addr 0x1234, bus_cmd 0; bus_rdata 0xBEEF -> mem_data_wr=1, mem_data_t_wr=1, mem_data_in 0xBEEF.
REQ-030 ex_rq and fe_rq both held continuously, STARVE_LIMIT 4 -> grant order core x4, fetch, core x4, fetch.
REQ-031 Core write addr 0x0010 data 0x00FF width 0, bus_ack after 2 cycles -> bus_wdata 0x00FF, bus_width 0, IDLE with no data pulse.
REQ-032 TIMEOUT 8, fetch read, bus_ack never -> err_timeout pulse 8 cycles after grant, bus_req low, no fe_data_wr.
REQ-033 a_rst=0 in WAIT, then bus_rvalid=1 with 0x5555 -> no data pulse; all outputs 0.
REQ-034 bus_rvalid and 8th timeout cycle on same edge -> fe_data_wr pulse, err_timeout stays 0.
